// File: rtl/plic_target_pkg.sv
// Shared PLIC definitions: width macros, target FSM state, reserved ID.
// No logic; types and constants only.
// Imported by the per-target claim/complete responder and its tracker.
`ifndef PLIC_PRIO_WIDTH
`define PLIC_PRIO_WIDTH 3
`endif
`ifndef PLIC_IRQ_WIDTH
`define PLIC_IRQ_WIDTH 5
`endif

package plic_target_pkg;

    localparam int unsigned PLIC_PRIO_W = `PLIC_PRIO_WIDTH;
    localparam int unsigned PLIC_IRQ_W  = `PLIC_IRQ_WIDTH;
    localparam int unsigned PLIC_IRQ_N  = 32;

    // ID 0 is reserved to mean "no interrupt pending".
    localparam int unsigned IRQ_ID_NONE = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BLANK = 1'b1
    } tgt_state_e;

endpackage

// File: rtl/plic_claim_tracker.sv
// Per-target record of claimed-but-not-completed interrupt IDs.
// Query is combinational; set/clear land on the next clock edge.
// No backpressure: a complete of an ID not currently claimed is refused via clr_ok_o.
module plic_claim_tracker
    import plic_target_pkg::*;
#(
    parameter int unsigned IRQ_NUM   = PLIC_IRQ_N,
    parameter int unsigned IRQ_WIDTH = $clog2(IRQ_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 set_i,
    input  logic [IRQ_WIDTH-1:0] set_id_i,
    input  logic                 clr_i,
    input  logic [IRQ_WIDTH-1:0] clr_id_i,
    output logic                 clr_ok_o
);

    logic [IRQ_NUM-1:0] claimed_q;
    logic [IRQ_NUM-1:0] claimed_d;
    logic               clr_in_range;
    logic               set_in_range;

    assign clr_in_range = (clr_id_i != IRQ_WIDTH'(IRQ_ID_NONE)) && (int'(clr_id_i) < int'(IRQ_NUM));
    assign set_in_range = (set_id_i != IRQ_WIDTH'(IRQ_ID_NONE)) && (int'(set_id_i) < int'(IRQ_NUM));

    // A complete is only honoured against the bit as it stood before this cycle.
    assign clr_ok_o = clr_i && clr_in_range && claimed_q[clr_id_i];

    // Clear first, then set, so a same-ID claim in the same cycle leaves the bit set.
    always_comb begin
        claimed_d = claimed_q;
        if (clr_ok_o) begin
            claimed_d[clr_id_i] = 1'b0;
        end
        if (set_i && set_in_range) begin
            claimed_d[set_id_i] = 1'b1;
        end
    end

    // Claimed-ID vector register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            claimed_q <= '0;
        end else begin
            claimed_q <= claimed_d;
        end
    end

endmodule

// File: rtl/plic_target.sv
// Per-target PLIC claim/complete responder with threshold compare and post-claim blanking.
// Latency: tree inputs -> irq_o/claim_id_o 1 clk; claim/complete -> gateway pulse 1 clk.
// No backpressure: strobes are single-cycle and always accepted or silently ignored.
module plic_target
    import plic_target_pkg::*;
#(
    parameter int unsigned PRIO_WIDTH = PLIC_PRIO_W,
    parameter int unsigned IRQ_NUM    = PLIC_IRQ_N,
    parameter int unsigned IRQ_WIDTH  = $clog2(IRQ_NUM),
    parameter int unsigned BLANK_CYC  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_WIDTH-1:0]  idx_i,
    input  logic [PRIO_WIDTH-1:0] thold_i,
    input  logic                  claim_i,
    output logic [IRQ_WIDTH-1:0]  claim_id_o,
    input  logic                  complete_i,
    input  logic [IRQ_WIDTH-1:0]  complete_id_i,
    output logic                  irq_o,
    output logic                  gw_claim_o,
    output logic [IRQ_WIDTH-1:0]  gw_claim_id_o,
    output logic                  gw_complete_o,
    output logic [IRQ_WIDTH-1:0]  gw_complete_id_o
);

    // Counter holds BLANK_CYC-1 down to 0; keep it at least one bit wide.
    localparam int unsigned       CNT_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [IRQ_WIDTH-1:0] ID_NONE = IRQ_WIDTH'(IRQ_ID_NONE);

    tgt_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IRQ_WIDTH-1:0]   best_id_q;
    logic                   irq_q;
    logic                   gw_claim_q;
    logic [IRQ_WIDTH-1:0]   gw_claim_id_q;
    logic                   gw_complete_q;
    logic [IRQ_WIDTH-1:0]   gw_complete_id_q;

    logic                   above_thold;
    logic                   claim_ok;
    logic                   complete_ok;

    // Strict unsigned compare, so priority 0 can never beat any threshold.
    assign above_thold = (prio_i > thold_i) && (idx_i != ID_NONE);

    // A claim only counts when the target is presenting a real ID.
    assign claim_ok = claim_i && (state_q == ST_IDLE) && irq_q;

    // While blanking, hide the just-claimed ID until its pending clear reaches the tree.
    assign irq_o      = (state_q == ST_IDLE) && irq_q;
    assign claim_id_o = (state_q == ST_IDLE) ? best_id_q : ID_NONE;

    assign gw_claim_o       = gw_claim_q;
    assign gw_claim_id_o    = gw_claim_id_q;
    assign gw_complete_o    = gw_complete_q;
    assign gw_complete_id_o = gw_complete_id_q;

    plic_claim_tracker #(
        .IRQ_NUM   (IRQ_NUM),
        .IRQ_WIDTH (IRQ_WIDTH)
    ) u_tracker (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .set_i    (claim_ok),
        .set_id_i (best_id_q),
        .clr_i    (complete_i),
        .clr_id_i (complete_id_i),
        .clr_ok_o (complete_ok)
    );

    // Stage register: threshold-qualified winner from the tree.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            best_id_q <= ID_NONE;
            irq_q     <= 1'b0;
        end else begin
            best_id_q <= above_thold ? idx_i : ID_NONE;
            irq_q     <= above_thold;
        end
    end

    // Claim FSM with blank counter and registered gateway claim pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            gw_claim_q    <= 1'b0;
            gw_claim_id_q <= ID_NONE;
        end else begin
            gw_claim_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (claim_ok) begin
                        state_q       <= ST_BLANK;
                        cnt_q         <= CNT_LOAD;
                        gw_claim_q    <= 1'b1;
                        gw_claim_id_q <= best_id_q;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered gateway complete pulse for accepted completes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gw_complete_q    <= 1'b0;
            gw_complete_id_q <= ID_NONE;
        end else begin
            gw_complete_q <= complete_ok;
            if (complete_ok) begin
                gw_complete_id_q <= complete_id_i;
            end
        end
    end

endmodule
